// File: rtl/burst_drain_pkg.sv
// Shared constants and state encoding for the burst capture/replay stage.
package burst_drain_pkg;

  localparam int unsigned DW    = 4;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;
  localparam int unsigned SW    = DW + AW;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/burst_drain_mem.sv
// DEPTH x DW register array: one write port, combinational read, async clear.
module burst_drain_mem #(
  parameter int unsigned DW    = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/burst_drain.sv
// Captures one DEPTH-sample burst, replays it over valid/ready and sums it.
module burst_drain
  import burst_drain_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] sum
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t        state, state_nxt;
  logic [AW-1:0] wptr, rptr;
  logic [DW-1:0] rdata;
  logic          we;

  burst_drain_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .rstn  (rstn),
    .we    (we),
    .waddr (wptr),
    .wdata (in_data),
    .raddr (rptr),
    .rdata (rdata)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    we        = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FILL;
      end
      FILL: begin
        busy = 1'b1;
        we   = in_valid;
        if (in_valid && (wptr == LAST_IDX)) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready && (rptr == LAST_IDX)) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Data is only presented while draining so idle/done cycles show zero.
  assign out_data = out_valid ? rdata : '0;
  assign out_last = out_valid && (rptr == LAST_IDX);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr <= '0;
      rptr <= '0;
      sum  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            wptr <= '0;
            sum  <= '0;
          end
        end
        FILL: begin
          if (in_valid) begin
            wptr <= wptr + AW'(1);
            sum  <= sum + SW'(in_data);
            if (wptr == LAST_IDX) rptr <= '0;
          end
        end
        DRAIN: begin
          if (out_ready) rptr <= rptr + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_burst_drain.sv
// Directed bench for burst_drain with a queue-based reference of capture/replay.
module tb_burst_drain;
  import burst_drain_pkg::*;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          busy;
  logic          done;
  logic [SW-1:0] sum;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  burst_drain dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done),
    .sum       (sum)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: samples accepted while capturing go into a queue; once DEPTH
  // are held the queue is replayed front-first, popping on each accepted beat.
  int            mode;       // 0 waiting, 1 capturing, 2 replaying, 3 finishing
  logic [DW-1:0] cap[$];
  logic [DW-1:0] rep[$];
  int            msum;
  bit            model_ok = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode = 0;
      cap.delete();
      rep.delete();
      msum = 0;
      model_ok = 1'b1;
    end else begin
      case (mode)
        0: if (start) begin
          mode = 1;
          cap.delete();
          msum = 0;
        end
        1: if (in_valid) begin
          cap.push_back(in_data);
          msum += int'(in_data);
          if (cap.size() == DEPTH) begin
            rep = cap;
            mode = 2;
          end
        end
        2: if (out_ready) begin
          void'(rep.pop_front());
          if (rep.size() == 0) mode = 3;
        end
        default: mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rstn && model_ok) begin
      check("out_valid", out_valid, mode == 2);
      check("busy", busy, (mode == 1) || (mode == 2));
      check("done", done, mode == 3);
      check("sum", sum, msum);
      check("out_last", out_last, (mode == 2) && (rep.size() == 1));
      if (mode == 2) check("out_data", out_data, rep[0]);
    end
  end

  int cyc = 0;
  int start_cyc = 0;
  int xfers = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int fv_cyc = -1;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rstn) begin
      if (out_valid && out_ready) xfers++;
      if (out_valid && fv_cyc < 0) fv_cyc = cyc - start_cyc + 1;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc - start_cyc + 1;
      end
    end
  end

  logic [DW-1:0] vals[DEPTH];
  bit            gpat[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  bit            rpat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_burst(input bit gapped, input bit bp, input int stop_after);
    int idx;
    int g;
    int k;
    xfers = 0;
    done_cnt = 0;
    done_cyc = -1;
    fv_cyc = -1;
    out_ready = 1'b1;
    in_valid = 1'b1;       // junk beat during IDLE must be ignored
    in_data = 4'hA;
    start = 1'b1;
    start_cyc = cyc + 1;
    tick();
    start = 1'b0;
    idx = 0;
    g = 0;
    while (idx < int'(DEPTH) && g < 200) begin
      in_valid = gapped ? gpat[g % 5] : 1'b1;
      in_data = vals[idx];
      tick();
      if (in_valid) idx++;
      g++;
    end
    in_valid = 1'b0;
    in_data = '0;
    if (g >= 200) check("fill_timeout", idx, DEPTH);
    k = 0;
    while (xfers < stop_after && k < 100) begin
      out_ready = bp ? rpat[k % 4] : 1'b1;
      start = bp;          // start while busy must be ignored
      tick();
      k++;
    end
    if (k >= 100) check("drain_timeout", xfers, stop_after);
    out_ready = 1'b1;
    if (stop_after == int'(DEPTH)) begin
      tick();
      start = 1'b0;
      tick();
    end
    start = 1'b0;
  endtask

  initial begin
    #3 rstn = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sum", sum, 0);
    tick();
    tick();
    @(negedge clk) rstn = 1'b1;
    tick();

    vals = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8};
    run_burst(1'b0, 1'b0, DEPTH);
    check("contig_sum", sum, 36);
    check("contig_first_valid_cyc", fv_cyc, 9);
    check("contig_done_cyc", done_cyc, 17);
    check("contig_xfers", xfers, 8);
    check("contig_done_cnt", done_cnt, 1);

    vals = '{4'd3, 4'd5, 4'd7, 4'd9, 4'd11, 4'd13, 4'd15, 4'd2};
    run_burst(1'b1, 1'b0, DEPTH);
    check("gap_sum", sum, 65);
    check("gap_xfers", xfers, 8);

    vals = '{4'd4, 4'd8, 4'd12, 4'd1, 4'd2, 4'd3, 4'd14, 4'd10};
    run_burst(1'b0, 1'b1, DEPTH);
    check("bp_sum", sum, 54);
    check("bp_xfers", xfers, 8);
    check("bp_done_cnt", done_cnt, 1);

    vals = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
    run_burst(1'b0, 1'b0, DEPTH);
    check("max_sum", sum, 7'b1111000);

    vals = '{4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
    run_burst(1'b0, 1'b0, 4);
    rstn = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done_cnt", done_cnt, 0);
    tick();
    @(negedge clk) rstn = 1'b1;
    tick();
    vals = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd10, 4'd12, 4'd14, 4'd0};
    run_burst(1'b0, 1'b0, DEPTH);
    check("after_rst_sum", sum, 56);
    check("after_rst_xfers", xfers, 8);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/burst_drain.md
Name: burst_drain

Overview:
Downstream stage of the counter-fed 8-entry x 4-bit capture buffer.
- Captures one burst of DEPTH samples from an upstream valid-qualified stream.
- Replays the samples in write order over a valid/ready output interface.
- Accumulates a running sum of the captured samples.
- Sits between the sample/counter source and any consumer, such as a checker or serializer.

Parameters:
DW, 4, sample width in bits
DEPTH, 8, burst length / buffer entries (power of two)
AW, 3, pointer width, log2(DEPTH)

Ports:
clk  input  1  clock, all state updates on posedge
rstn  input  1  reset, asynchronous, active-low
start  input  1  begin a capture burst; sampled only in IDLE
in_data  input  DW  upstream sample
in_valid  input  1  in_data is valid this cycle; no backpressure to upstream
out_data  output  DW  replayed sample
out_valid  output  1  out_data is valid
out_ready  input  1  consumer accepts out_data
out_last  output  1  current out_data is the final entry (index DEPTH-1)
busy  output  1  high in FILL and DRAIN
done  output  1  one-cycle pulse after the last output transfer
sum  output  DW+AW  sum of the DEPTH captured samples

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE; wptr=0; rptr=0.
  - All buffer entries=0.
  - out_valid=0, out_data=0, out_last=0, busy=0, done=0, sum=0.
- Reset asserted mid-FILL or mid-DRAIN aborts the burst immediately; nothing is retained.
- States: IDLE, FILL, DRAIN, DONE. The state is registered.
- IDLE:
  - start=1 -> FILL next cycle; wptr<=0, sum<=0.
  - start=0 -> stay in IDLE.
  - in_valid is ignored in IDLE.
- FILL:
  - busy=1.
  - Each cycle with in_valid=1: buffer[wptr]<=in_data, wptr<=wptr+1, sum<=sum+in_data (zero-extended).
  - in_valid=0 holds wptr and sum (gap tolerated indefinitely).
  - The write at wptr==DEPTH-1 -> DRAIN next cycle; rptr<=0; wptr wraps to 0.
- DRAIN:
  - busy=1, out_valid=1.
  - out_data=buffer[rptr].
  - out_last=(rptr==DEPTH-1).
  - Transfer occurs when out_valid&&out_ready: rptr<=rptr+1.
  - out_data and out_last are held stable while out_ready=0.
  - Transfer with out_last=1 -> DONE next cycle; out_valid drops that same edge.
- DONE:
  - done=1 for exactly one cycle, busy=0, out_valid=0.
  - Return to IDLE next cycle.
  - start during DONE is ignored.
- Latency:
  - First write occurs the cycle after start, when in_valid is high.
  - out_valid rises the cycle after the final write.
  - done asserts the cycle after the final transfer.
- Arithmetic: sum is DW+AW bits, so the maximum DEPTH*(2^DW-1)=120 fits in 7 bits and no overflow is possible. sum is held from the end of FILL until the next accepted start.
- start while busy: ignored; it has no effect on the burst.
- Buffer contents persist after DONE and are overwritten by the next burst.

Decomposition:
- Shared package holds:
  - DW, DEPTH, AW constants.
  - State enum (IDLE, FILL, DRAIN, DONE).
- One natural sub-module: burst_drain_mem.
  - DEPTH x DW register array.
  - Async clear to 0 on rstn.
  - Single write port (we, waddr, wdata), combinational read (raddr -> rdata).
- FSM, pointers and sum stay in burst_drain.

Test Plan:
- Reset: drive rstn=0 at t=3ns -> all outputs 0 immediately (asynchronous); state IDLE after release.
- Contiguous burst: start at cycle 0, in_data=1..8 with in_valid=1 on cycles 1-8, out_ready=1:
  - out_valid high cycles 9-16 with out_data 1..8.
  - out_last only on 8.
  - done pulse at cycle 17; sum=36; busy low at 17.
- Gapped input: in_valid pattern 1,0,1,1,0,... carrying 8 samples 3,5,7,9,11,13,15,2 -> same order replayed, sum=65, no entry skipped or duplicated.
- Backpressure: out_ready toggles 1,0,0,1,... during DRAIN -> out_data/out_last unchanged while out_ready=0, exactly 8 transfers, done once.
- Max values: all in_data=15 -> sum=120 (7'b1111000), no wrap.
- Mid-drain reset, then new burst: rstn low after 4 transfers -> out_valid=0, sum=0 at once; after release, start plus 8 new samples replays only the new data.
